// File: rtl/median_pkg.sv
// Shared types and constants for the binary 3x3 median frame scanner.
package median_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DRAIN = 3'd2,
    ST_EMIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int ADDR_W   = 8;
  localparam int SUM_W    = 4;
  localparam int WIN_TAPS = 9;
  localparam int K_W      = 4;

  // Window taps in row-major order, top-left first.
  localparam logic signed [1:0] DX [0:8] = '{
    -2'sd1, 2'sd0, 2'sd1,
    -2'sd1, 2'sd0, 2'sd1,
    -2'sd1, 2'sd0, 2'sd1
  };
  localparam logic signed [1:0] DY [0:8] = '{
    -2'sd1, -2'sd1, -2'sd1,
     2'sd0,  2'sd0,  2'sd0,
     2'sd1,  2'sd1,  2'sd1
  };

endpackage

// File: rtl/median_nbr_addr.sv
// Neighbour address generator: maps pixel (x, y) and tap k to a frame address.
module median_nbr_addr
  import median_pkg::*;
#(
  parameter int WIDTH  = 128,
  parameter int HEIGHT = 128
) (
  input  logic [ADDR_W-1:0] x_i,
  input  logic [ADDR_W-1:0] y_i,
  input  logic [K_W-1:0]    k_i,
  output logic [ADDR_W-1:0] rd_x_o,
  output logic [ADDR_W-1:0] rd_y_o,
  output logic              in_range_o
);

  logic [K_W-1:0]    idx;
  logic signed [1:0] dx;
  logic signed [1:0] dy;
  logic signed [8:0] nx;
  logic signed [8:0] ny;
  logic              x_ok;
  logic              y_ok;

  // 9-bit signed sums: -1 and 256 both land with bit 8 set, so edges never wrap into the frame.
  always_comb begin
    idx        = (k_i < K_W'(WIN_TAPS)) ? k_i : '0;
    dx         = DX[idx];
    dy         = DY[idx];
    nx         = $signed({1'b0, x_i}) + $signed({{7{dx[1]}}, dx});
    ny         = $signed({1'b0, y_i}) + $signed({{7{dy[1]}}, dy});
    x_ok       = !nx[8] && (nx[7:0] <= ADDR_W'(WIDTH - 1));
    y_ok       = !ny[8] && (ny[7:0] <= ADDR_W'(HEIGHT - 1));
    in_range_o = x_ok && y_ok;
    rd_x_o     = in_range_o ? nx[7:0] : '0;
    rd_y_o     = in_range_o ? ny[7:0] : '0;
  end

endmodule

// File: rtl/median_scan_ctrl.sv
// Frame sequencer for the binary 3x3 median filter: raster scan, 9-tap fetch,
// popcount threshold, and pixel output over a write/writeReady handshake.
module median_scan_ctrl
  import median_pkg::*;
#(
  parameter int WIDTH     = 128,
  parameter int HEIGHT    = 128,
  parameter int THRESHOLD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              startFilter,
  output logic              busy,
  output logic              done,
  output logic              rdEn,
  output logic [ADDR_W-1:0] rdX,
  output logic [ADDR_W-1:0] rdY,
  input  logic              rdData,
  output logic [ADDR_W-1:0] xAddress,
  output logic [ADDR_W-1:0] yAddress,
  output logic              eventOut,
  output logic              write,
  input  logic              writeReady
);

  // Handshake: a pixel transfers on a rising edge where write && writeReady;
  // write, xAddress, yAddress and eventOut are registered and hold until then.

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  x_q, x_d, y_q, y_d;
  logic [K_W-1:0]     k_q, k_d;
  logic [SUM_W-1:0]   sum_q, sum_d, sum_in;
  logic               pend_q, pend_d;
  logic               write_q, write_d, event_q, event_d;
  logic [ADDR_W-1:0]  xaddr_q, xaddr_d, yaddr_q, yaddr_d;
  logic [ADDR_W-1:0]  nbr_x, nbr_y;
  logic               nbr_ok, last_k, last_x, last_y, xfer;

  median_nbr_addr #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_nbr (
    .x_i        (x_q),
    .y_i        (y_q),
    .k_i        (k_q),
    .rd_x_o     (nbr_x),
    .rd_y_o     (nbr_y),
    .in_range_o (nbr_ok)
  );

  assign last_k = (k_q == K_W'(WIN_TAPS - 1));
  assign last_x = (x_q == ADDR_W'(WIDTH - 1));
  assign last_y = (y_q == ADDR_W'(HEIGHT - 1));
  assign xfer   = (state_q == ST_EMIT) && write_q && writeReady;
  // pend_q marks that last cycle issued a read, so rdData is valid now.
  assign sum_in = sum_q + {{(SUM_W-1){1'b0}}, pend_q & rdData};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (startFilter) state_d = ST_FETCH;
      ST_FETCH: if (last_k) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_EMIT;
      ST_EMIT:  if (xfer) state_d = (last_x && last_y) ? ST_DONE : ST_FETCH;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_DONE);
    rdEn = 1'b0;
    rdX  = '0;
    rdY  = '0;
    if (state_q == ST_FETCH && nbr_ok) begin
      rdEn = 1'b1;
      rdX  = nbr_x;
      rdY  = nbr_y;
    end
  end

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    k_d     = k_q;
    sum_d   = sum_q;
    pend_d  = 1'b0;
    write_d = write_q;
    xaddr_d = xaddr_q;
    yaddr_d = yaddr_q;
    event_d = event_q;
    unique case (state_q)
      ST_IDLE: begin
        if (startFilter) begin
          x_d   = '0;
          y_d   = '0;
          k_d   = '0;
          sum_d = '0;
        end
      end
      ST_FETCH: begin
        sum_d  = sum_in;
        pend_d = rdEn;
        k_d    = last_k ? '0 : k_q + 1'b1;
      end
      ST_DRAIN: begin
        sum_d   = sum_in;
        write_d = 1'b1;
        xaddr_d = x_q;
        yaddr_d = y_q;
        event_d = (sum_in > SUM_W'(THRESHOLD));
      end
      ST_EMIT: begin
        if (xfer) begin
          write_d = 1'b0;
          xaddr_d = '0;
          yaddr_d = '0;
          event_d = 1'b0;
          sum_d   = '0;
          k_d     = '0;
          if (last_x && last_y) begin
            x_d = '0;
            y_d = '0;
          end else if (last_x) begin
            x_d = '0;
            y_d = y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      k_q     <= '0;
      sum_q   <= '0;
      pend_q  <= 1'b0;
      write_q <= 1'b0;
      xaddr_q <= '0;
      yaddr_q <= '0;
      event_q <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      k_q     <= k_d;
      sum_q   <= sum_d;
      pend_q  <= pend_d;
      write_q <= write_d;
      xaddr_q <= xaddr_d;
      yaddr_q <= yaddr_d;
      event_q <= event_d;
    end
  end

  assign write    = write_q;
  assign xAddress = xaddr_q;
  assign yAddress = yaddr_q;
  assign eventOut = event_q;

endmodule

// File: tb/tb_median_scan_ctrl.sv
// Directed bench for median_scan_ctrl: 4x4 and 5x5 instances checked against a window-count model.
module tb_median_scan_ctrl;

  localparam int WA  = 4;
  localparam int HA  = 4;
  localparam int WB  = 5;
  localparam int HB  = 5;
  localparam int THR = 4;

  logic clk;
  int   n_chk = 0;
  int   n_fail = 0;

  // ---- instance A (4x4) ----
  logic       rst_a, start_a, busy_a, done_a, rden_a, rdd_a, ev_a, wr_a, wrdy_a;
  logic [7:0] rdx_a, rdy_a, xa_a, ya_a;
  logic       mem_a [0:WA*HA-1];
  logic [16:0] exp_qa [$];
  int         busy_cnt_a, done_cnt_a, exp_len_a;
  logic       stalled_a;
  logic [16:0] held_a;

  // ---- instance B (5x5) ----
  logic       rst_b, start_b, busy_b, done_b, rden_b, rdd_b, ev_b, wr_b, wrdy_b;
  logic [7:0] rdx_b, rdy_b, xa_b, ya_b;
  logic       mem_b [0:WB*HB-1];
  logic [16:0] exp_qb [$];
  int         busy_cnt_b, done_cnt_b, exp_len_b;

  median_scan_ctrl #(.WIDTH(WA), .HEIGHT(HA), .THRESHOLD(THR)) u_dut_a (
    .clk(clk), .reset(rst_a), .startFilter(start_a), .busy(busy_a), .done(done_a),
    .rdEn(rden_a), .rdX(rdx_a), .rdY(rdy_a), .rdData(rdd_a),
    .xAddress(xa_a), .yAddress(ya_a), .eventOut(ev_a), .write(wr_a), .writeReady(wrdy_a)
  );

  median_scan_ctrl #(.WIDTH(WB), .HEIGHT(HB), .THRESHOLD(THR)) u_dut_b (
    .clk(clk), .reset(rst_b), .startFilter(start_b), .busy(busy_b), .done(done_b),
    .rdEn(rden_b), .rdX(rdx_b), .rdY(rdy_b), .rdData(rdd_b),
    .xAddress(xa_b), .yAddress(ya_b), .eventOut(ev_b), .write(wr_b), .writeReady(wrdy_b)
  );

  // ---- clock / reset ----
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // ---- frame memories: data one cycle after the strobe, noise otherwise ----
  always @(posedge clk) begin
    rdd_a <= rden_a ? mem_a[int'(rdy_a) * WA + int'(rdx_a)] : 1'($urandom);
    rdd_b <= rden_b ? mem_b[int'(rdy_b) * WB + int'(rdx_b)] : 1'($urandom);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---- behavioural model: 3x3 window population count ----
  function automatic int cnt_a(input int x, input int y);
    int c = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if (x + dx >= 0 && x + dx < WA && y + dy >= 0 && y + dy < HA)
          c += int'(mem_a[(y + dy) * WA + x + dx]);
    return c;
  endfunction

  function automatic int cnt_b(input int x, input int y);
    int c = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if (x + dx >= 0 && x + dx < WB && y + dy >= 0 && y + dy < HB)
          c += int'(mem_b[(y + dy) * WB + x + dx]);
    return c;
  endfunction

  // ---- driver tasks ----
  task automatic start_frame_a(input int len);
    exp_qa.delete();
    for (int y = 0; y < HA; y++)
      for (int x = 0; x < WA; x++)
        exp_qa.push_back({8'(x), 8'(y), (cnt_a(x, y) > THR) ? 1'b1 : 1'b0});
    exp_len_a  = len;
    busy_cnt_a = 0;
    done_cnt_a = 0;
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
  endtask

  task automatic start_frame_b(input int len);
    exp_qb.delete();
    for (int y = 0; y < HB; y++)
      for (int x = 0; x < WB; x++)
        exp_qb.push_back({8'(x), 8'(y), (cnt_b(x, y) > THR) ? 1'b1 : 1'b0});
    exp_len_b  = len;
    busy_cnt_b = 0;
    done_cnt_b = 0;
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
  endtask

  task automatic pulse_start_a();
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
  endtask

  task automatic wait_write_a(input int x, input int y);
    int  n = 0;
    logic seen = 1'b0;
    while (!seen && n < 3000) begin
      @(negedge clk);
      n++;
      seen = wr_a && (xa_a == 8'(x)) && (ya_a == 8'(y));
    end
    check("wait_write_a", 32'(seen), 32'd1);
  endtask

  task automatic wait_done_a();
    int  n = 0;
    logic seen = 1'b0;
    while (!seen && n < 3000) begin
      @(negedge clk);
      n++;
      seen = done_a;
    end
    check("wait_done_a", 32'(seen), 32'd1);
  endtask

  task automatic wait_done_b();
    int  n = 0;
    logic seen = 1'b0;
    while (!seen && n < 3000) begin
      @(negedge clk);
      n++;
      seen = done_b;
    end
    check("wait_done_b", 32'(seen), 32'd1);
  endtask

  // ---- scoreboard / compare, instance A ----
  always @(negedge clk) begin
    if (rst_a) begin
      stalled_a = 1'b0;
    end else begin
      if (busy_a) busy_cnt_a++;
      if (rden_a) check("rd_in_frame_a", 32'(rdx_a < 8'(WA) && rdy_a < 8'(HA)), 32'd1);
      if (stalled_a) begin
        check("stall_hold_a", 32'({wr_a, xa_a, ya_a, ev_a}), 32'({1'b1, held_a}));
        check("stall_no_read_a", 32'(rden_a), 32'd0);
      end
      if (wr_a && wrdy_a) begin
        if (exp_qa.size() == 0) check("write_expected_a", 32'd0, 32'd1);
        else check("pixel_a", 32'({xa_a, ya_a, ev_a}), 32'(exp_qa.pop_front()));
      end
      stalled_a = wr_a && !wrdy_a;
      held_a    = {xa_a, ya_a, ev_a};
      if (done_a) begin
        done_cnt_a++;
        check("done_queue_empty_a", 32'(exp_qa.size()), 32'd0);
        if (exp_len_a != 0) check("frame_len_a", 32'(busy_cnt_a), 32'(exp_len_a));
      end
    end
  end

  // ---- scoreboard / compare, instance B ----
  always @(negedge clk) begin
    if (!rst_b) begin
      if (busy_b) busy_cnt_b++;
      if (rden_b) check("rd_in_frame_b", 32'(rdx_b < 8'(WB) && rdy_b < 8'(HB)), 32'd1);
      if (wr_b && wrdy_b) begin
        if (exp_qb.size() == 0) check("write_expected_b", 32'd0, 32'd1);
        else check("pixel_b", 32'({xa_b, ya_b, ev_b}), 32'(exp_qb.pop_front()));
      end
      if (done_b) begin
        done_cnt_b++;
        check("done_queue_empty_b", 32'(exp_qb.size()), 32'd0);
        check("frame_len_b", 32'(busy_cnt_b), 32'(exp_len_b));
      end
    end
  end

  // ---- directed sequence ----
  initial begin
    logic [15:0] pat;
    rst_a = 1'b1; start_a = 1'b0; wrdy_a = 1'b1;
    rst_b = 1'b1; start_b = 1'b0; wrdy_b = 1'b1;
    busy_cnt_a = 0; done_cnt_a = 0; exp_len_a = 0;
    busy_cnt_b = 0; done_cnt_b = 0; exp_len_b = 0;
    stalled_a = 1'b0; held_a = '0;
    for (int i = 0; i < WA * HA; i++) mem_a[i] = 1'b0;
    for (int i = 0; i < WB * HB; i++) mem_b[i] = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_done_a", 32'(done_a), 32'd0);
    check("rst_rd_a", 32'({rden_a, rdx_a, rdy_a}), 32'd0);
    check("rst_out_a", 32'({wr_a, xa_a, ya_a, ev_a}), 32'd0);
    check("rst_out_b", 32'({busy_b, done_b, rden_b, wr_b}), 32'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("idle_no_start_a", 32'(busy_a), 32'd0);

    // Frame 1: all-zero 4x4, no backpressure.
    check("pin_zero_cnt", 32'(cnt_a(1, 1)), 32'd0);
    start_frame_a(177);
    wait_done_a();
    repeat (5) @(posedge clk);
    #1 check("one_done_f1", 32'(done_cnt_a), 32'd1);

    // Frame 2: all-one 4x4 with a 5-cycle stall on pixel (1,0).
    for (int i = 0; i < WA * HA; i++) mem_a[i] = 1'b1;
    check("pin_ones_corner", 32'(cnt_a(0, 0)), 32'd4);
    check("pin_ones_edge", 32'(cnt_a(1, 0)), 32'd6);
    check("pin_ones_inner", 32'(cnt_a(2, 1)), 32'd9);
    check("pin_ones_far_corner", 32'(cnt_a(3, 3)), 32'd4);
    start_frame_a(182);
    wait_write_a(0, 0);
    check("corner_ev_0_0", 32'(ev_a), 32'd0);
    @(posedge clk); #1 wrdy_a = 1'b0;
    wait_write_a(1, 0);
    check("edge_ev_1_0", 32'(ev_a), 32'd1);
    repeat (5) @(posedge clk);
    #1 wrdy_a = 1'b1;
    wait_done_a();
    repeat (5) @(posedge clk);
    #1 check("one_done_f2", 32'(done_cnt_a), 32'd1);

    // Frame 3: mixed pattern, reset during fetch of pixel (2,1).
    pat = 16'hB6C9;
    for (int i = 0; i < WA * HA; i++) mem_a[i] = pat[i];
    check("pin_pat_1_1", 32'(cnt_a(1, 1)), 32'd4);
    check("pin_pat_2_1", 32'(cnt_a(2, 1)), 32'd5);
    check("pin_pat_2_2", 32'(cnt_a(2, 2)), 32'd6);
    start_frame_a(0);
    wait_write_a(1, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_read", 32'({rden_a, rdx_a, rdy_a}), 32'({1'b1, 8'd2, 8'd0}));
    #2 rst_a = 1'b1;
    #1;
    check("async_rst_busy", 32'({busy_a, done_a}), 32'd0);
    check("async_rst_rd", 32'({rden_a, rdx_a, rdy_a}), 32'd0);
    check("async_rst_out", 32'({wr_a, xa_a, ya_a, ev_a}), 32'd0);
    @(posedge clk); #1 rst_a = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt_a), 32'd0);
    check("abort_idle", 32'(busy_a), 32'd0);

    // Frame 4: rescan same pattern; stray starts while busy and in DONE.
    start_frame_a(177);
    repeat (30) @(posedge clk);
    pulse_start_a();
    wait_write_a(3, 3);
    @(posedge clk); #1;
    check("in_done_state", 32'({done_a, busy_a}), 32'd3);
    start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    check("done_exits_idle", 32'(busy_a), 32'd0);
    repeat (20) @(posedge clk);
    #1;
    check("done_start_ignored", 32'(busy_a), 32'd0);
    check("one_done_f4", 32'(done_cnt_a), 32'd1);

    // Frame 5: single salt pixel in a 5x5 frame.
    mem_b[2 * WB + 2] = 1'b1;
    check("pin_salt_centre", 32'(cnt_b(2, 2)), 32'd1);
    check("pin_salt_diag", 32'(cnt_b(1, 1)), 32'd1);
    check("pin_salt_far", 32'(cnt_b(0, 0)), 32'd0);
    start_frame_b(276);
    wait_done_b();
    repeat (5) @(posedge clk);
    #1 check("one_done_b", 32'(done_cnt_b), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
